// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath widths and the control-bit bundle
// carried by the ID/EX, EX/MEM and MEM/WB stage registers.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic is_jump;
        logic reg_wrenable;
        logic mem_wrenable;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_cmp.sv
// Forwarding and load-use detection from the registered EX/MEM contents.
// Purely combinational; r0 is never a forwarding or hazard source.
module hazard_cmp
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned REG_W  = cpu_pkg::REG_W
) (
    input  logic              valid,
    input  ctrl_t             ctrl,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] write_data,
    input  logic [REG_W-1:0]  ex_rs1,
    input  logic [REG_W-1:0]  ex_rs2,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_use
);

    logic writes_rd;
    logic rs_match;

    always_comb begin
        writes_rd = valid & ctrl.reg_wrenable & (rd != '0);
        rs_match  = (rd == ex_rs1) | (rd == ex_rs2);
        // Load data only exists after the synchronous RAM read, so a load is
        // reported as a hazard and never bypassed.
        fwd_en    = writes_rd & ~ctrl.mem_to_reg;
        load_use  = writes_rd & ctrl.mem_to_reg & rs_match;
        fwd_rd    = rd;
        fwd_data  = ctrl.is_jump ? write_data : alu_res;
    end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush > stall > load priority, bypass and
// load-use reporting, and a saturating stalled-cycle counter.
module ex_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned REG_W  = cpu_pkg::REG_W,
    parameter int unsigned CNT_W  = cpu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              is_jump_in,
    input  logic              reg_wrenable_in,
    input  logic              mem_wrenable_in,
    input  logic              mem_to_reg_in,
    input  logic [REG_W-1:0]  ex_rs1,
    input  logic [REG_W-1:0]  ex_rs2,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] write_data,
    output logic [REG_W-1:0]  rd,
    output logic              is_jump,
    output logic              reg_wrenable,
    output logic              mem_wrenable,
    output logic              mem_to_reg,
    output logic              valid,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_use,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic              valid_q,        valid_d;
    ctrl_t             ctrl_q,         ctrl_d;
    logic [DATA_W-1:0] alu_res_q,      alu_res_d;
    logic [DATA_W-1:0] write_data_q,   write_data_d;
    logic [REG_W-1:0]  rd_q,           rd_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    ctrl_t ctrl_in;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the
        // if/else chain can leave one unassigned and infer a latch.
        valid_d        = valid_q;
        ctrl_d         = ctrl_q;
        alu_res_d      = alu_res_q;
        write_data_d   = write_data_q;
        rd_d           = rd_q;
        stall_cycles_d = stall_cycles_q;

        ctrl_in = '{
            is_jump:      is_jump_in,
            reg_wrenable: reg_wrenable_in & (rd_in != '0),
            mem_wrenable: mem_wrenable_in,
            mem_to_reg:   mem_to_reg_in
        };

        if (flush) begin
            valid_d      = 1'b0;
            ctrl_d       = CTRL_BUBBLE;
            alu_res_d    = '0;
            write_data_d = '0;
            rd_d         = '0;
        end else if (stall) begin
            if (stall_cycles_q != {CNT_W{1'b1}}) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
        end else begin
            // An invalid slot registers as a bubble, which also keeps
            // mem_wrenable low whenever valid is low.
            valid_d      = in_valid;
            ctrl_d       = in_valid ? ctrl_in : CTRL_BUBBLE;
            alu_res_d    = alu_res_in;
            write_data_d = write_data_in;
            rd_d         = rd_in;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; the datapath is reset too because all outputs must read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            ctrl_q         <= CTRL_BUBBLE;
            alu_res_q      <= '0;
            write_data_q   <= '0;
            rd_q           <= '0;
            stall_cycles_q <= '0;
        end else begin
            valid_q        <= valid_d;
            ctrl_q         <= ctrl_d;
            alu_res_q      <= alu_res_d;
            write_data_q   <= write_data_d;
            rd_q           <= rd_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign alu_res      = alu_res_q;
    assign write_data   = write_data_q;
    assign rd           = rd_q;
    assign is_jump      = ctrl_q.is_jump;
    assign reg_wrenable = ctrl_q.reg_wrenable;
    assign mem_wrenable = ctrl_q.mem_wrenable;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign valid        = valid_q;
    assign stall_cycles = stall_cycles_q;

    hazard_cmp #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_hazard_cmp (
        .valid      (valid_q),
        .ctrl       (ctrl_q),
        .rd         (rd_q),
        .alu_res    (alu_res_q),
        .write_data (write_data_q),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .fwd_en     (fwd_en),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .load_use   (load_use)
    );

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: a behavioural model pushes expected outputs
// when stimulus is driven; they are popped and compared after the edge.
module tb_ex_mem;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i, flush_i, in_valid_i;
    logic [DW-1:0] alu_res_in_i, write_data_in_i;
    logic [RW-1:0] rd_in_i, ex_rs1_i, ex_rs2_i;
    logic          is_jump_in_i, reg_we_in_i, mem_we_in_i, m2r_in_i;

    logic [DW-1:0] alu_res_o, write_data_o, fwd_data_o;
    logic [RW-1:0] rd_o, fwd_rd_o;
    logic          is_jump_o, reg_we_o, mem_we_o, m2r_o, valid_o, fwd_en_o, load_use_o;
    logic [CW-1:0] stall_cycles_o;

    always #5 clk = ~clk;

    ex_mem #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall_i),
        .flush           (flush_i),
        .in_valid        (in_valid_i),
        .alu_res_in      (alu_res_in_i),
        .write_data_in   (write_data_in_i),
        .rd_in           (rd_in_i),
        .is_jump_in      (is_jump_in_i),
        .reg_wrenable_in (reg_we_in_i),
        .mem_wrenable_in (mem_we_in_i),
        .mem_to_reg_in   (m2r_in_i),
        .ex_rs1          (ex_rs1_i),
        .ex_rs2          (ex_rs2_i),
        .alu_res         (alu_res_o),
        .write_data      (write_data_o),
        .rd              (rd_o),
        .is_jump         (is_jump_o),
        .reg_wrenable    (reg_we_o),
        .mem_wrenable    (mem_we_o),
        .mem_to_reg      (m2r_o),
        .valid           (valid_o),
        .fwd_en          (fwd_en_o),
        .fwd_rd          (fwd_rd_o),
        .fwd_data        (fwd_data_o),
        .load_use        (load_use_o),
        .stall_cycles    (stall_cycles_o)
    );

    typedef struct {
        logic          valid, j, rwe, mwe, m2r;
        logic [DW-1:0] alu, wd;
        logic [RW-1:0] rd;
        logic [CW-1:0] cnt;
    } mdl_t;

    typedef struct {
        mdl_t          s;
        logic          fwd_en, load_use;
        logic [RW-1:0] fwd_rd;
        logic [DW-1:0] fwd_data;
    } exp_t;

    mdl_t m;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t zero_state();
        mdl_t z;
        z = '{valid: 1'b0, j: 1'b0, rwe: 1'b0, mwe: 1'b0, m2r: 1'b0,
              alu: '0, wd: '0, rd: '0, cnt: '0};
        return z;
    endfunction

    function automatic mdl_t next_state(mdl_t s);
        mdl_t n;
        n = s;
        if (flush_i) begin
            n.valid = 1'b0; n.j = 1'b0; n.rwe = 1'b0; n.mwe = 1'b0; n.m2r = 1'b0;
            n.alu = '0; n.wd = '0; n.rd = '0;
        end else if (stall_i) begin
            if (n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
        end else begin
            n.valid = in_valid_i;
            n.j     = in_valid_i & is_jump_in_i;
            n.rwe   = in_valid_i & reg_we_in_i & (rd_in_i != 0);
            n.mwe   = in_valid_i & mem_we_in_i;
            n.m2r   = in_valid_i & m2r_in_i;
            n.alu   = alu_res_in_i;
            n.wd    = write_data_in_i;
            n.rd    = rd_in_i;
        end
        return n;
    endfunction

    function automatic exp_t expect_of(mdl_t s);
        exp_t e;
        e.s        = s;
        e.fwd_en   = s.valid & s.rwe & ~s.m2r & (s.rd != 0);
        e.load_use = s.valid & s.rwe & s.m2r & (s.rd != 0) &
                     ((s.rd == ex_rs1_i) | (s.rd == ex_rs2_i));
        e.fwd_rd   = s.rd;
        e.fwd_data = s.j ? s.wd : s.alu;
        return e;
    endfunction

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_valid"},    valid_o,        e.s.valid);
        check({tag, "_is_jump"},  is_jump_o,      e.s.j);
        check({tag, "_reg_we"},   reg_we_o,       e.s.rwe);
        check({tag, "_mem_we"},   mem_we_o,       e.s.mwe);
        check({tag, "_m2r"},      m2r_o,          e.s.m2r);
        check({tag, "_alu_res"},  alu_res_o,      e.s.alu);
        check({tag, "_wdata"},    write_data_o,   e.s.wd);
        check({tag, "_rd"},       rd_o,           e.s.rd);
        check({tag, "_fwd_en"},   fwd_en_o,       e.fwd_en);
        check({tag, "_fwd_rd"},   fwd_rd_o,       e.fwd_rd);
        check({tag, "_fwd_data"}, fwd_data_o,     e.fwd_data);
        check({tag, "_load_use"}, load_use_o,     e.load_use);
        check({tag, "_stall_cnt"}, stall_cycles_o, e.s.cnt);
    endtask

    // Predict the effect of the next rising edge, then compare just after it.
    task automatic tick(input string tag);
        m = next_state(m);
        sb.push_back(expect_of(m));
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                          input logic [RW-1:0] r, input logic j, input logic rwe,
                          input logic mwe, input logic m2r);
        in_valid_i = v; alu_res_in_i = alu; write_data_in_i = wd; rd_in_i = r;
        is_jump_in_i = j; reg_we_in_i = rwe; mem_we_in_i = mwe; m2r_in_i = m2r;
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m = zero_state();
        sb.push_back(expect_of(m));
        compare_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0;
        ex_rs1_i = '0; ex_rs2_i = '0;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        m = zero_state();
        #12;
        sb.push_back(expect_of(m));
        compare_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain ALU result becomes a forwarding source.
        set_in(1'b1, 32'h10, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("alu_load");
        check("alu_load_fwd_data_const", fwd_data_o, 32'h10);
        check("alu_load_fwd_en_const",   fwd_en_o,   1'b1);

        // Load instruction: hazard reported, never forwarded.
        set_in(1'b1, 32'h44, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        ex_rs1_i = 5'd0; ex_rs2_i = 5'd5;
        tick("ld_use");
        check("ld_use_const",     load_use_o, 1'b1);
        check("ld_fwd_off_const", fwd_en_o,   1'b0);
        ex_rs2_i = 5'd6;
        #1;
        sb.push_back(expect_of(m));
        compare_outputs("ld_rs_miss");
        check("ld_rs_miss_const", load_use_o, 1'b0);

        // Three stalled cycles with changing inputs hold the register.
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'hA0 + i, 32'hB0 + i, 5'(7 + i), 1'b1, 1'b1, 1'b1, 1'b0);
            tick("stall_hold");
        end
        check("stall3_cnt_const", stall_cycles_o, 16'd3);

        // Flush wins over stall and does not count as a stalled cycle.
        set_in(1'b1, 32'h1, 32'h2, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        flush_i = 1'b1;
        tick("stall_flush");
        check("stall_flush_cnt_const", stall_cycles_o, 16'd3);
        stall_i = 1'b0; flush_i = 1'b0;

        // Jump forwards pc+1, and r0 never becomes writable.
        set_in(1'b1, 32'h80, 32'h21, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
        tick("jump");
        check("jump_fwd_data_const", fwd_data_o, 32'h21);
        set_in(1'b1, 32'h55, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("rd_zero");

        // Store, then an invalid slot that must register as a bubble.
        set_in(1'b1, 32'h100, 32'hDEAD, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("store");
        set_in(1'b0, 32'h200, 32'hBEEF, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        tick("bubble");

        // Mixed random traffic with small register indices to provoke matches.
        for (int i = 0; i < 40; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            ex_rs1_i = 5'($urandom_range(0, 3));
            ex_rs2_i = 5'($urandom_range(0, 3));
            stall_i  = ($urandom_range(0, 3) == 0);
            flush_i  = ($urandom_range(0, 7) == 0);
            tick("rand");
        end
        flush_i = 1'b0;

        // Drive the counter to the top and confirm it saturates.
        stall_i = 1'b1;
        while (m.cnt < 16'hFFFE) begin
            m = next_state(m);
            @(posedge clk);
        end
        #1;
        sb.push_back(expect_of(m));
        compare_outputs("cnt_fffe");
        for (int i = 0; i < 3; i++) tick("cnt_sat");
        check("cnt_sat_const", stall_cycles_o, 16'hFFFF);
        stall_i = 1'b0;

        async_reset("async_rst");

        // Reset while stalled discards the held instruction.
        set_in(1'b1, 32'h33, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("pre_rst_load");
        stall_i = 1'b1;
        tick("pre_rst_stall");
        async_reset("rst_mid_stall");
        tick("post_rst_stall");
        stall_i = 1'b0;
        set_in(1'b1, 32'h77, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("post_rst_load");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter REG_W, default 5, register-index width.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 stall  in  1  hold all pipeline contents this cycle.
REQ-007 flush  in  1  replace contents with a bubble this cycle.
REQ-008 in_valid  in  1  EX stage presents a real instruction.
REQ-009 alu_res_in, write_data_in  in  DATA_W  ALU result; store data, or pc+1 for jumps.
REQ-010 rd_in  in  REG_W  destination register index.
REQ-011 is_jump_in, reg_wrenable_in, mem_wrenable_in, mem_to_reg_in  in  1 each  control bits from decode.
REQ-012 ex_rs1, ex_rs2  in  REG_W  source indices of the instruction now in EX.
REQ-013 alu_res, write_data  out  DATA_W  registered copies, fed to the MEM/WB stage.
REQ-014 rd, is_jump, reg_wrenable, mem_wrenable, mem_to_reg, valid  out  registered copies.
REQ-015 fwd_en  out  1  fwd_data is usable for an EX bypass of register fwd_rd.
REQ-016 fwd_rd  out  REG_W; fwd_data  out  DATA_W.
REQ-017 load_use  out  1  EX operand depends on a load held in this stage.
REQ-018 stall_cycles  out  CNT_W  saturating count of stalled cycles.

Function
REQ-019 Per-edge update priority SHALL be: flush > stall > load.
REQ-020 Load: every registered field SHALL take its _in value; valid SHALL take in_valid. Latency is 1 cycle.
REQ-021 Stall without flush: all registered fields and valid SHALL hold unchanged.
REQ-022 Flush: valid, is_jump, reg_wrenable, mem_wrenable and mem_to_reg SHALL clear to 0; alu_res, write_data and rd SHALL clear to 0. Flush takes effect even when stall is also asserted.
REQ-023 When in_valid=0 on a load cycle, all control outputs SHALL register as 0, giving a bubble.
REQ-024 When rd_in=0 on a load cycle, reg_wrenable SHALL register as 0, because r0 is hardwired.
REQ-025 Output mem_wrenable SHALL never be 1 while valid=0.
REQ-026 fwd_en = valid & reg_wrenable & ~mem_to_reg & (rd!=0). Combinational from registered state.
REQ-027 fwd_data = is_jump ? write_data : alu_res. fwd_rd = rd.
REQ-028 load_use = valid & reg_wrenable & mem_to_reg & (rd!=0) & ((rd==ex_rs1) | (rd==ex_rs2)). Combinational.
REQ-029 Loads SHALL never be forwarded. Load data comes from synchronous RAM in the next stage; the hazard is reported through load_use only.
REQ-030 stall_cycles SHALL increment by 1 on each edge where stall=1 and flush=0.
REQ-031 stall_cycles SHALL saturate at all-ones and never wrap.
REQ-032 stall_cycles SHALL NOT be cleared by flush.

Reset
REQ-033 While rst_n=0, all outputs SHALL be 0 asynchronously, stall_cycles included.
REQ-034 Deassertion SHALL be synchronised externally. The first edge after deassertion obeys REQ-019.
REQ-035 Reset mid-stall SHALL discard the held instruction. After release, valid=0 until a load occurs.

Structure
REQ-036 DATA_W, REG_W and the control-bit bundle layout {is_jump, reg_wrenable, mem_wrenable, mem_to_reg} SHALL live in the shared cpu package or include. The ID/EX and MEM/WB stages reuse it.
REQ-037 One sub-module, hazard_cmp, SHALL implement REQ-026..REQ-028 combinationally. The pipeline register and counter stay in ex_mem.

Verification
REQ-038 Load alu_res_in=0x10, rd_in=3, reg_wrenable_in=1, in_valid=1 -> next cycle alu_res=0x10, rd=3, fwd_en=1, fwd_data=0x10.
REQ-039 Load a load instruction (mem_to_reg=1, rd=5) with ex_rs2=5 -> load_use=1 and fwd_en=0; set ex_rs2=6 -> load_use=0.
REQ-040 Hold stall=1 for 3 cycles with changing inputs -> outputs unchanged and stall_cycles=3; assert stall and flush together -> valid=0, mem_wrenable=0, stall_cycles still 3.
REQ-041 Load a jump (is_jump=1, write_data_in=0x21, alu_res_in=0x80, rd=31) -> fwd_data=0x21. Load rd_in=0 with reg_wrenable_in=1 -> reg_wrenable=0, fwd_en=0.
REQ-042 Force stall_cycles to 0xFFFE and stall 3 cycles -> stall_cycles=0xFFFF. Pull rst_n low between clock edges -> all outputs 0 immediately.
